fp_mx_quantizer: RTL and testbench
==================================

// Module: fp_mx_quantizer
// PURPOSE
//  Output-side converter of the MX tensor core: takes the FP32-style accumulator results (sign, biased exp,
//  23b mantissa without implicit 1) produced by the FP adder and re-encodes them into an MXFP8 block:
//  one shared E8M0 scale plus BLOCK_SIZE E4M3 elements. It buffers one block, finds the max exponent,
//  derives the scale, then streams quantized elements out. It is the encoding end of the adder's number format.
// PARAMETERS
//  BLOCK_SIZE   32  elements per MX block (power of 2, >=2)
//  M_IN_WIDTH   23  input mantissa width (fraction only, implicit 1 not stored)
// PORTS
//  clk_i        in   1           clock
//  rst_ni       in   1           async reset, active low
//  in_valid_i   in   1           input element valid
//  in_ready_o   out  1           input element accepted when valid&ready
//  in_sign_i    in   1           element sign
//  in_exp_i     in   8           element biased exponent (bias 127; 0 = zero/denormal)
//  in_mant_i    in   M_IN_WIDTH  element fraction
//  out_valid_o  out  1           output element valid
//  out_ready_i  in   1           downstream accepts when valid&ready
//  out_elem_o   out  8           E4M3 element {s,eeee,mmm}
//  out_scale_o  out  8           E8M0 shared scale, constant for the whole emitted block
//  out_last_o   out  1           high with final element of the block
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state COLLECT, counters 0, buffer cleared, max_exp 0; in_ready_o=1,
//    out_valid_o=0, out_elem_o=0, out_scale_o=0, out_last_o=0. Reset mid-block discards the block.
//  - FSM COLLECT: in_ready_o=1; each handshake writes buffer[wr_idx], wr_idx++, max_exp=max(max_exp,in_exp_i).
//    On handshake with wr_idx==BLOCK_SIZE-1 (incl. that element's exp): register scale, wr_idx=0 -> EMIT.
//  - FSM EMIT: in_ready_o=0, out_valid_o=1; out_elem_o = quant(buffer[rd_idx]); out_last_o=(rd_idx==BLOCK_SIZE-1).
//    Handshake: rd_idx++; on last -> rd_idx=0, max_exp=0, COLLECT. No handshake: all outputs held stable.
//  - Latency: first element valid the cycle after the last input handshake; 1 element/cycle without stall.
//    Throughput: BLOCK_SIZE in + BLOCK_SIZE out cycles per block (single buffer, no overlap).
//  - Scale: scale = (max_exp >= 8) ? max_exp-8 : 0 (E4M3 emax=8). 0xFF never produced by arithmetic.
//  - Element: in_exp_i==0 -> 0x00 with sign kept. Otherwise e_out = in_exp - scale + 7 (10b signed).
//    e_out>=1: normal, mant = top 3 fraction bits, rounded; e_out<=0: subnormal, {1,frac} >> (1-e_out),
//    rounded into 3b; shift >= 5 -> 0. Round carry bumps exponent/normalizes subnormal->normal.
//  - Saturation: result > 448 (e_out>15, or e_out==15 & mant==111 i.e. NaN code) -> {s,0x7E}. No NaN/Inf out.
//  - in_exp_i==0xFF treated as a finite huge value (saturates); accumulator never generates it.
// CONFIGURATION
//  MX_QUANT_RNE_EN defined: round-to-nearest-even on dropped bits (guard/round/sticky).
//  Undefined: truncation toward zero; no rounding carry path. All other behaviour identical.
// STRUCTURE
//  Package mx_pkg: E4M3_EMAX=8, E4M3_BIAS=7, E4M3_MAXNORM=7'h7E, FP32_BIAS=127, typedef fp_elem_t
//  {sign,exp[7:0],mant}, typedef enum {COLLECT,EMIT} quant_state_e.
//  Sub-module mx_e4m3_quant: purely combinational fp_elem_t + scale -> 8b E4M3 (rounding, subnormal,
//  saturation); fp_mx_quantizer holds buffer, FSM, counters, max tracking.
// TESTING
//  1) 32 x (+1.0: exp 127, mant 0) -> scale 0x77, 32 elems 0x78, out_last on 32nd only.
//  2) elem0 -1.0, rest 0 (exp 0) -> scale 0x77, elem0 0xF8, others 0x00.
//  3) max +1.0 plus elem exp127 mant 0x700000 -> 0x7E (NaN code saturated); mant 0x7FFFFF -> 0x7E (RNE carry).
//  4) max +1.0, elem exp 112 -> 0x04 (subnormal); elem exp 100 -> 0x00; all-zero block -> scale 0x00, elems 0x00.
//  5) out_ready_i low 5 cycles mid-EMIT -> outputs stable, in_ready_o=0; assert rst_ni mid-COLLECT -> all reset values, next block correct.
//  6) MX_QUANT_RNE_EN off: max 1.0, elem exp127 mant 0x1C0000 -> 0x79 (truncate); on -> 0x7A.

Source files
------------

// File: rtl/fp_mx_quantizer_pkg.sv
// Shared types and constants for the MX output quantizer (FP32-style accumulator -> MXFP8 E4M3 + E8M0).
package mx_pkg;

    localparam int E4M3_EMAX = 8;
    localparam int E4M3_BIAS = 7;
    localparam logic [6:0] E4M3_MAXNORM = 7'h7E;
    localparam int FP32_BIAS = 127;
    localparam int FP_MANT_W = 23;

    typedef struct packed {
        logic                 sign;
        logic [7:0]           exp;
        logic [FP_MANT_W-1:0] mant;
    } fp_elem_t;

    typedef enum logic {
        COLLECT,
        EMIT
    } quant_state_e;

    // Shared scale puts the block maximum at the top E4M3 binade (2^8).
    function automatic logic [7:0] mx_scale_from_exp(input logic [7:0] max_exp);
        return (max_exp >= 8'(E4M3_EMAX)) ? max_exp - 8'(E4M3_EMAX) : 8'h00;
    endfunction

endpackage

// File: rtl/fp_mx_quantizer_if.sv
// Element-in / element-out stream bundle of the MX quantizer; slave is the quantizer side.
interface fp_mx_quantizer_if #(
    parameter int M_IN_WIDTH = 23
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  in_sign_i;
    logic [7:0]            in_exp_i;
    logic [M_IN_WIDTH-1:0] in_mant_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [7:0]            out_elem_o;
    logic [7:0]            out_scale_o;
    logic                  out_last_o;

    modport master (
        output in_valid_i, in_sign_i, in_exp_i, in_mant_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_elem_o, out_scale_o, out_last_o
    );

    modport slave (
        input  in_valid_i, in_sign_i, in_exp_i, in_mant_i, out_ready_i,
        output in_ready_o, out_valid_o, out_elem_o, out_scale_o, out_last_o
    );
endinterface

// File: rtl/fp_mx_quantizer_e4m3_quant.sv
// Combinational FP32-style element + E8M0 scale -> E4M3 code (subnormals, saturation to +-448).
// MX_QUANT_RNE_EN selects round-to-nearest-even; otherwise dropped bits are truncated.
module mx_e4m3_quant
    import mx_pkg::*;
(
    input  fp_elem_t   elem,
    input  logic [7:0] scale,
    output logic [7:0] code
);

`ifdef MX_QUANT_RNE_EN
    localparam bit ROUND_NEAREST_EVEN = 1'b1;
`else
    localparam bit ROUND_NEAREST_EVEN = 1'b0;
`endif

    logic signed [9:0] e_out;
    logic              normal;
    logic              flush;
    logic [2:0]        shamt;
    logic [46:0]       shifted;
    logic [2:0]        mant3;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [3:0]        exp_field;
    logic [7:0]        sum;

    // Subnormals reuse the normal datapath: the significand (hidden 1 at bit 46)
    // is shifted right so the first three fraction positions always hold the result.
    // A rounding carry out of mant3 naturally ripples into the exponent field.
    always_comb begin
        e_out     = $signed({2'b00, elem.exp}) - $signed({2'b00, scale}) + 10'(E4M3_BIAS);
        normal    = (e_out > 10'sd0);
        flush     = (e_out < -10'sd3);
        shamt     = normal ? 3'd0 : 3'(10'sd1 - e_out);
        shifted   = {1'b1, elem.mant, 23'b0} >> shamt;
        mant3     = shifted[45:43];
        guard     = shifted[42];
        sticky    = |shifted[41:0];
        round_up  = ROUND_NEAREST_EVEN && guard && (sticky || mant3[0]);
        exp_field = shifted[46] ? e_out[3:0] : 4'd0;
        sum       = {1'b0, exp_field, mant3} + {7'b0, round_up};

        code = {elem.sign, 7'h00};
        if (elem.exp == 8'h00 || flush) begin
            code = {elem.sign, 7'h00};
        end else if (e_out > 10'sd15 || sum > {1'b0, E4M3_MAXNORM}) begin
            code = {elem.sign, E4M3_MAXNORM};
        end else begin
            code = {elem.sign, sum[6:0]};
        end
    end

endmodule

// File: rtl/fp_mx_quantizer.sv
// MX block quantizer: buffers BLOCK_SIZE FP32-style elements, derives the E8M0 scale, streams E4M3 out.
// Rounding mode is selected by MX_QUANT_RNE_EN (see mx_e4m3_quant).
module fp_mx_quantizer
    import mx_pkg::*;
#(
    parameter int BLOCK_SIZE = 32,
    parameter int M_IN_WIDTH = 23
) (
    input logic                clk_i,
    input logic                rst_ni,
    fp_mx_quantizer_if.slave   bus
);

    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    quant_state_e          state;
    quant_state_e          state_next;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [7:0]            max_exp;
    logic [7:0]            max_exp_merged;
    logic [7:0]            scale_q;
    fp_elem_t              buffer [BLOCK_SIZE];
    fp_elem_t              in_elem;
    fp_elem_t              rd_elem;
    logic [FP_MANT_W-1:0]  in_mant_ext;
    logic [7:0]            quant_code;
    logic                  in_fire;
    logic                  out_fire;
    logic                  wr_last;
    logic                  rd_last;

    // Narrower input fractions are left-aligned so the binary point stays put.
    generate
        if (M_IN_WIDTH == FP_MANT_W) begin : g_mant_exact
            assign in_mant_ext = bus.in_mant_i;
        end else begin : g_mant_pad
            assign in_mant_ext = {bus.in_mant_i, {(FP_MANT_W - M_IN_WIDTH){1'b0}}};
        end
    endgenerate

    assign in_elem        = {bus.in_sign_i, bus.in_exp_i, in_mant_ext};
    assign in_fire        = (state == COLLECT) && bus.in_valid_i;
    assign out_fire       = (state == EMIT) && bus.out_ready_i;
    assign wr_last        = (wr_idx == LAST_IDX);
    assign rd_last        = (rd_idx == LAST_IDX);
    assign max_exp_merged = (bus.in_exp_i > max_exp) ? bus.in_exp_i : max_exp;
    assign rd_elem        = buffer[rd_idx];

    mx_e4m3_quant u_quant (
        .elem  (rd_elem),
        .scale (scale_q),
        .code  (quant_code)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= COLLECT;
            wr_idx  <= '0;
            rd_idx  <= '0;
            max_exp <= 8'h00;
            scale_q <= 8'h00;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (in_fire) begin
                buffer[wr_idx] <= in_elem;
                max_exp        <= max_exp_merged;
                if (wr_last) begin
                    wr_idx  <= '0;
                    scale_q <= mx_scale_from_exp(max_exp_merged);
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
            if (out_fire) begin
                if (rd_last) begin
                    rd_idx  <= '0;
                    max_exp <= 8'h00;
                end else begin
                    rd_idx <= rd_idx + IDX_W'(1);
                end
            end
        end
    end

    // Single buffer: collection and emission never overlap, so ready/valid are pure state decodes.
    always_comb begin
        state_next       = state;
        bus.in_ready_o   = 1'b0;
        bus.out_valid_o  = 1'b0;
        bus.out_elem_o   = 8'h00;
        bus.out_scale_o  = 8'h00;
        bus.out_last_o   = 1'b0;
        unique case (state)
            COLLECT: begin
                bus.in_ready_o = 1'b1;
                if (in_fire && wr_last) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                bus.out_valid_o = 1'b1;
                bus.out_elem_o  = quant_code;
                bus.out_scale_o = scale_q;
                bus.out_last_o  = rd_last;
                if (out_fire && rd_last) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_fp_mx_quantizer.sv
// Self-checking bench for fp_mx_quantizer: directed blocks plus random blocks against a real-valued model.
module tb_fp_mx_quantizer;
    import mx_pkg::*;

    localparam int BS = 32;
    localparam int MW = 23;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic       blk_sign [BS];
    logic [7:0] blk_exp  [BS];
    logic [22:0] blk_mant [BS];

    always #5 clk = ~clk;

    fp_mx_quantizer_if #(.M_IN_WIDTH(MW)) bus ();

    fp_mx_quantizer #(.BLOCK_SIZE(BS), .M_IN_WIDTH(MW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Reference: element value x = 1.m * 2^ue relative to the shared scale, quantized on the
    // E4M3 grid (3 fraction bits per binade, fixed 2^-9 step below 2^-6), saturating above 448.
    function automatic logic [7:0] model_elem(input logic s, input logic [7:0] e,
                                              input logic [22:0] m, input logic [7:0] sc);
        int  ue;
        int  k;
        int  ni;
        int  ce;
        int  cm;
        real n;
        real fl;
        if (e == 8'h00) return {s, 7'h00};
        ue = (int'(e) - FP32_BIAS) - (int'(sc) - FP32_BIAS);
        k  = (ue >= -6) ? 3 : ue + 9;
        n  = 1.0 + real'(m) / 8388608.0;
        for (int i = 0; i < k; i++) n = n * 2.0;
        for (int i = 0; i < -k; i++) n = n / 2.0;
        fl = $floor(n);
        ni = int'(fl);
`ifdef MX_QUANT_RNE_EN
        if ((n - fl) > 0.5 || ((n - fl) == 0.5 && (ni % 2) == 1)) ni = ni + 1;
`endif
        if (ue >= -6) begin
            ce = ue + 7;
            cm = ni - 8;
            if (cm == 8) begin
                ce = ce + 1;
                cm = 0;
            end
            if (ce > 15 || (ce == 15 && cm == 7)) return {s, 7'h7E};
            return {s, 4'(ce), 3'(cm)};
        end
        return {s, 7'(ni)};
    endfunction

    function automatic logic [7:0] model_scale();
        int mx = 0;
        for (int i = 0; i < BS; i++) if (int'(blk_exp[i]) > mx) mx = int'(blk_exp[i]);
        return (mx >= 8) ? 8'(mx - 8) : 8'h00;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
        checkOutput({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
        checkOutput({tag, "_out_elem"}, 32'(bus.out_elem_o), 32'd0);
        checkOutput({tag, "_out_scale"}, 32'(bus.out_scale_o), 32'd0);
        checkOutput({tag, "_out_last"}, 32'(bus.out_last_o), 32'd0);
    endtask

    task automatic sendElem(input logic s, input logic [7:0] e, input logic [22:0] m);
        int n = 0;
        bus.in_valid_i = 1'b1;
        bus.in_sign_i  = s;
        bus.in_exp_i   = e;
        bus.in_mant_i  = m;
        while (bus.in_ready_o !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) checkOutput("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic fillConst(input logic s, input logic [7:0] e, input logic [22:0] m);
        for (int i = 0; i < BS; i++) begin
            blk_sign[i] = s;
            blk_exp[i]  = e;
            blk_mant[i] = m;
        end
    endtask

    task automatic fillRandom(input int center);
        int t;
        for (int i = 0; i < BS; i++) begin
            t = center - int'($urandom_range(0, 18));
            if (t < 1) t = 1;
            blk_exp[i]  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'(t);
            blk_sign[i] = 1'($urandom);
            blk_mant[i] = ($urandom_range(0, 3) == 0) ? 23'($urandom_range(0, 15)) << 19
                                                      : 23'($urandom);
        end
    endtask

    // Sends the staged block, then drains and checks it; stalls out_ready for stall_len cycles at stall_at.
    task automatic applyStimulus(input string tag, input int stall_at, input int stall_len);
        logic [7:0] sc;
        logic [7:0] exp_elem;
        int         n;
        sc = model_scale();
        for (int i = 0; i < BS; i++) sendElem(blk_sign[i], blk_exp[i], blk_mant[i]);
        checkOutput({tag, "_first_valid"}, 32'(bus.out_valid_o), 32'd1);
        checkOutput({tag, "_in_ready_emit"}, 32'(bus.in_ready_o), 32'd0);
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < BS; i++) begin
            n = 0;
            while (bus.out_valid_o !== 1'b1 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 100) checkOutput({tag, "_out_valid_timeout"}, 32'd0, 32'd1);
            exp_elem = model_elem(blk_sign[i], blk_exp[i], blk_mant[i], sc);
            checkOutput($sformatf("%s_elem%0d", tag, i), 32'(bus.out_elem_o), 32'(exp_elem));
            checkOutput($sformatf("%s_scale%0d", tag, i), 32'(bus.out_scale_o), 32'(sc));
            checkOutput($sformatf("%s_last%0d", tag, i), 32'(bus.out_last_o), 32'(i == BS - 1));
            if (i == stall_at && stall_len > 0) begin
                bus.out_ready_i = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    @(posedge clk); #1;
                    checkOutput($sformatf("%s_stall_valid%0d", tag, k), 32'(bus.out_valid_o), 32'd1);
                    checkOutput($sformatf("%s_stall_elem%0d", tag, k), 32'(bus.out_elem_o), 32'(exp_elem));
                    checkOutput($sformatf("%s_stall_scale%0d", tag, k), 32'(bus.out_scale_o), 32'(sc));
                    checkOutput($sformatf("%s_stall_last%0d", tag, k), 32'(bus.out_last_o), 32'(i == BS - 1));
                    checkOutput($sformatf("%s_stall_in_ready%0d", tag, k), 32'(bus.in_ready_o), 32'd0);
                end
                bus.out_ready_i = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.out_ready_i = 1'b0;
        checkOutput({tag, "_done_valid"}, 32'(bus.out_valid_o), 32'd0);
        checkOutput({tag, "_done_in_ready"}, 32'(bus.in_ready_o), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_sign_i   = 1'b0;
        bus.in_exp_i    = 8'h00;
        bus.in_mant_i   = '0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] block of +1.0");
        fillConst(1'b0, 8'd127, 23'h0);
        applyStimulus("ones", -1, 0);

        $display("[TB] -1.0 followed by zeros");
        fillConst(1'b0, 8'h00, 23'h0);
        blk_sign[0] = 1'b1;
        blk_exp[0]  = 8'd127;
        applyStimulus("neg_one", -1, 0);

        $display("[TB] saturation, rounding and subnormal corners");
        fillConst(1'b0, 8'h00, 23'h0);
        blk_exp[0] = 8'd127;
        blk_exp[1] = 8'd127;  blk_mant[1] = 23'h700000;
        blk_exp[2] = 8'd127;  blk_mant[2] = 23'h7FFFFF;
        blk_exp[3] = 8'd127;  blk_mant[3] = 23'h1C0000;
        blk_exp[4] = 8'd112;
        blk_exp[5] = 8'd100;
        blk_exp[6] = 8'd113;  blk_mant[6] = 23'h7FFFFF;  blk_sign[6] = 1'b1;
        blk_exp[7] = 8'd109;  blk_mant[7] = 23'h000001;
        blk_exp[8] = 8'd108;  blk_mant[8] = 23'h400000;
        blk_exp[9] = 8'd120;  blk_mant[9] = 23'h180000;
        applyStimulus("corners", -1, 0);

        $display("[TB] all-zero block");
        fillConst(1'b0, 8'h00, 23'h0);
        applyStimulus("zeros", -1, 0);

        $display("[TB] output stall mid-block");
        fillRandom(130);
        applyStimulus("stall", 10, 5);

        $display("[TB] reset in the middle of collection");
        fillRandom(90);
        for (int i = 0; i < 10; i++) sendElem(blk_sign[i], blk_exp[i], blk_mant[i]);
        rst_n = 1'b0;
        #2;
        checkReset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fillRandom(200);
        applyStimulus("after_reset", -1, 0);

        $display("[TB] randomized blocks");
        for (int b = 0; b < 6; b++) begin
            case (b)
                0: fillRandom(5);
                1: fillRandom(255);
                default: fillRandom(int'($urandom_range(10, 250)));
            endcase
            applyStimulus($sformatf("rand%0d", b), int'($urandom_range(0, BS - 1)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
